control_sequencer: RTL

//  Hardwired multi-cycle control unit for the RISC datapath. It sequences fetch (T0-T2) and per-class execute steps (T3-T7).
//  It drives every register enable, bus select, Gra/Grb/Grc, ALUCode and memread/memwrite line.

---
 rtl/ctrl_pkg.sv | 118 +++++++++++
 rtl/control_decode.sv | 99 +++++++++
 rtl/control_sequencer.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - opcodes, ALU codes, state encoding and control word for the control sequencer
package ctrl_pkg;

   localparam logic [4:0] OP_LD   = 5'd0;
   localparam logic [4:0] OP_LDI  = 5'd1;
   localparam logic [4:0] OP_ST   = 5'd2;
   localparam logic [4:0] OP_ADD  = 5'd3;
   localparam logic [4:0] OP_SUB  = 5'd4;
   localparam logic [4:0] OP_AND  = 5'd5;
   localparam logic [4:0] OP_OR   = 5'd6;
   localparam logic [4:0] OP_SHR  = 5'd7;
   localparam logic [4:0] OP_SHRA = 5'd8;
   localparam logic [4:0] OP_SHL  = 5'd9;
   localparam logic [4:0] OP_ROR  = 5'd10;
   localparam logic [4:0] OP_ROL  = 5'd11;
   localparam logic [4:0] OP_ADDI = 5'd12;
   localparam logic [4:0] OP_ANDI = 5'd13;
   localparam logic [4:0] OP_ORI  = 5'd14;
   localparam logic [4:0] OP_MUL  = 5'd15;
   localparam logic [4:0] OP_DIV  = 5'd16;
   localparam logic [4:0] OP_NEG  = 5'd17;
   localparam logic [4:0] OP_NOT  = 5'd18;
   localparam logic [4:0] OP_BR   = 5'd19;
   localparam logic [4:0] OP_JR   = 5'd20;
   localparam logic [4:0] OP_IN   = 5'd22;
   localparam logic [4:0] OP_OUT  = 5'd23;
   localparam logic [4:0] OP_MFLO = 5'd24;
   localparam logic [4:0] OP_MFHI = 5'd25;
   localparam logic [4:0] OP_NOP  = 5'd26;
   localparam logic [4:0] OP_HALT = 5'd27;

   // ALU-class operations reuse their opcode as the ALU code; INC sits on an unused opcode value.
   localparam logic [4:0] ALU_ADD = OP_ADD;
   localparam logic [4:0] ALU_INC = 5'd21;

   typedef enum logic [3:0] {
      S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7,
      S_MWAIT, S_PAUSE, S_HALT
   } state_t;

   typedef enum logic [3:0] {
      C_ALU3, C_ALUI, C_MULDIV, C_UNARY, C_LD, C_LDI, C_ST, C_BR,
      C_JR, C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP, C_HALT, C_ILL
   } op_class_t;

   typedef struct packed {
      logic       hi_in;
      logic       lo_in;
      logic       z_in;
      logic       pc_in;
      logic       mdr_in;
      logic       mar_in;
      logic       y_in;
      logic       oport_in;
      logic       ir_in;
      logic       hi_sel;
      logic       lo_sel;
      logic       zhi_sel;
      logic       zlo_sel;
      logic       pc_sel;
      logic       mdr_sel;
      logic       iport_sel;
      logic       c_sel;
      logic       gra;
      logic       grb;
      logic       grc;
      logic       r_in;
      logic       r_out;
      logic       ba_out;
      logic       con_in;
      logic       mem_read;
      logic       mem_write;
      logic [4:0] alu_code;
      logic       run;
      logic       illegal_op;
   } ctrl_word_t;

   localparam int CW_W = $bits(ctrl_word_t);

   // Group opcodes by the shape of their execute sequence.
   function automatic op_class_t classify(input logic [4:0] op);
      op_class_t cls;
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
         OP_SHRA, OP_SHL, OP_ROR, OP_ROL:      cls = C_ALU3;
         OP_ADDI, OP_ANDI, OP_ORI:             cls = C_ALUI;
         OP_MUL, OP_DIV:                       cls = C_MULDIV;
         OP_NEG, OP_NOT:                       cls = C_UNARY;
         OP_LD:                                cls = C_LD;
         OP_LDI:                               cls = C_LDI;
         OP_ST:                                cls = C_ST;
         OP_BR:                                cls = C_BR;
         OP_JR:                                cls = C_JR;
         OP_IN:                                cls = C_IN;
         OP_OUT:                               cls = C_OUT;
         OP_MFHI:                              cls = C_MFHI;
         OP_MFLO:                              cls = C_MFLO;
         OP_NOP:                               cls = C_NOP;
         OP_HALT:                              cls = C_HALT;
         default:                              cls = C_ILL;
      endcase
      return cls;
   endfunction

   // Final execute step of each class; MWAIT stretching of T6 is handled separately.
   function automatic state_t last_step(input op_class_t cls);
      state_t s;
      case (cls)
         C_ALU3, C_ALUI, C_LDI:      s = S_T5;
         C_MULDIV, C_ST, C_BR:       s = S_T6;
         C_UNARY:                    s = S_T4;
         C_LD:                       s = S_T7;
         default:                    s = S_T3;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/control_decode.sv
// rtl/control_decode.sv - combinational control word from state, opcode and branch condition
module control_decode
   import ctrl_pkg::*;
(
   input  logic [3:0]      state,
   input  logic [4:0]      opcode,
   input  logic            con_out,
   output logic [CW_W-1:0] word
);

   state_t     st;
   op_class_t  cls;
   ctrl_word_t cw;

   assign st   = state_t'(state);
   assign cls  = classify(opcode);
   assign word = cw;

   // Per-step line assertions; MWAIT repeats the T6 word so strobes stay steady.
   always_comb begin
      cw = '0;
      case (st)
         S_T0: begin
            cw.pc_sel = 1'b1; cw.mar_in = 1'b1; cw.z_in = 1'b1; cw.alu_code = ALU_INC;
         end
         S_T1: begin
            cw.zlo_sel = 1'b1; cw.pc_in = 1'b1; cw.mem_read = 1'b1; cw.mdr_in = 1'b1;
         end
         S_T2: begin
            cw.mdr_sel = 1'b1; cw.ir_in = 1'b1;
         end
         S_T3: begin
            case (cls)
               C_ALU3, C_ALUI: begin cw.grb = 1'b1; cw.r_out = 1'b1; cw.y_in = 1'b1; end
               C_MULDIV:       begin cw.gra = 1'b1; cw.r_out = 1'b1; cw.y_in = 1'b1; end
               C_UNARY: begin
                  cw.grb = 1'b1; cw.r_out = 1'b1; cw.z_in = 1'b1; cw.alu_code = opcode;
               end
               C_LD, C_LDI, C_ST: begin cw.grb = 1'b1; cw.ba_out = 1'b1; cw.y_in = 1'b1; end
               C_BR:   begin cw.gra = 1'b1; cw.r_out = 1'b1; cw.con_in = 1'b1; end
               C_JR:   begin cw.gra = 1'b1; cw.r_out = 1'b1; cw.pc_in = 1'b1; end
               C_IN:   begin cw.iport_sel = 1'b1; cw.gra = 1'b1; cw.r_in = 1'b1; end
               C_OUT:  begin cw.gra = 1'b1; cw.r_out = 1'b1; cw.oport_in = 1'b1; end
               C_MFHI: begin cw.hi_sel = 1'b1; cw.gra = 1'b1; cw.r_in = 1'b1; end
               C_MFLO: begin cw.lo_sel = 1'b1; cw.gra = 1'b1; cw.r_in = 1'b1; end
               C_ILL:  cw.illegal_op = 1'b1;
               default: ;
            endcase
         end
         S_T4: begin
            case (cls)
               C_ALU3: begin
                  cw.grc = 1'b1; cw.r_out = 1'b1; cw.z_in = 1'b1; cw.alu_code = opcode;
               end
               C_ALUI: begin cw.c_sel = 1'b1; cw.z_in = 1'b1; cw.alu_code = opcode; end
               C_MULDIV: begin
                  cw.grb = 1'b1; cw.r_out = 1'b1; cw.z_in = 1'b1; cw.alu_code = opcode;
               end
               C_UNARY: begin cw.zlo_sel = 1'b1; cw.gra = 1'b1; cw.r_in = 1'b1; end
               C_LD, C_LDI, C_ST: begin
                  cw.c_sel = 1'b1; cw.z_in = 1'b1; cw.alu_code = ALU_ADD;
               end
               C_BR: begin cw.pc_sel = 1'b1; cw.y_in = 1'b1; end
               default: ;
            endcase
         end
         S_T5: begin
            case (cls)
               C_ALU3, C_ALUI, C_LDI: begin cw.zlo_sel = 1'b1; cw.gra = 1'b1; cw.r_in = 1'b1; end
               C_MULDIV:    begin cw.zlo_sel = 1'b1; cw.lo_in = 1'b1; end
               C_LD, C_ST:  begin cw.zlo_sel = 1'b1; cw.mar_in = 1'b1; end
               C_BR: begin cw.c_sel = 1'b1; cw.z_in = 1'b1; cw.alu_code = ALU_ADD; end
               default: ;
            endcase
         end
         S_T6, S_MWAIT: begin
            case (cls)
               C_MULDIV: begin cw.zhi_sel = 1'b1; cw.hi_in = 1'b1; end
               C_LD:     begin cw.mem_read = 1'b1; cw.mdr_in = 1'b1; end
               C_ST:     begin cw.gra = 1'b1; cw.r_out = 1'b1; cw.mem_write = 1'b1; end
               C_BR: begin
                  if (con_out) begin
                     cw.zlo_sel = 1'b1; cw.pc_in = 1'b1;
                  end
               end
               default: ;
            endcase
         end
         S_T7: begin
            if (cls == C_LD) begin
               cw.mdr_sel = 1'b1; cw.gra = 1'b1; cw.r_in = 1'b1;
            end
         end
         default: ;
      endcase
      cw.run = st inside {S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_MWAIT};
   end

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - hardwired multi-cycle control unit: state register, memory wait and stop/halt
module control_sequencer
   import ctrl_pkg::*;
#(
   parameter int MEM_WAIT = 0
)
(
   input  logic        clock,
   input  logic        clear,
   input  logic [31:0] IR,
   input  logic        ConOut,
   input  logic        Stop,
   output logic        HiIn,
   output logic        LoIn,
   output logic        ZIn,
   output logic        PCIn,
   output logic        MDRIn,
   output logic        MARIn,
   output logic        YIn,
   output logic        OPortIn,
   output logic        IRIn,
   output logic        HiSel,
   output logic        LoSel,
   output logic        ZHiSel,
   output logic        ZLoSel,
   output logic        PCSel,
   output logic        MDRSel,
   output logic        IPortSel,
   output logic        CSel,
   output logic        Gra,
   output logic        Grb,
   output logic        Grc,
   output logic        RIn,
   output logic        ROut,
   output logic        BAOut,
   output logic        ConIn,
   output logic        memread,
   output logic        memwrite,
   output logic [4:0]  ALUCode,
   output logic        Run,
   output logic        IllegalOp
);

   localparam logic [2:0] WAIT_INIT = 3'(MEM_WAIT - 1);

   state_t          state;
   logic [2:0]      wait_cnt;
   logic [4:0]      opcode;
   op_class_t       cls;
   state_t          last;
   logic [CW_W-1:0] word;
   ctrl_word_t      cw;
   logic            unused_ir;

   assign opcode    = IR[31:27];
   assign cls       = classify(opcode);
   assign last      = last_step(cls);
   assign unused_ir = ^IR[26:0];

   control_decode u_decode (
      .state   (state),
      .opcode  (opcode),
      .con_out (ConOut),
      .word    (word)
   );

   assign cw = ctrl_word_t'(word);

   // Step sequencing: fetch, class-specific execute, T6 stretch for memory, stop/halt handling.
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state    <= S_RST;
         wait_cnt <= '0;
      end else begin
         case (state)
            S_RST: state <= S_T0;
            S_T0:  state <= S_T1;
            S_T1:  state <= S_T2;
            S_T2:  state <= S_T3;
            S_T3, S_T4, S_T5, S_T6, S_T7: begin
               if (state == S_T3 && cls == C_HALT) begin
                  state <= S_HALT;
               end else if (state == S_T6 && (cls == C_LD || cls == C_ST) && MEM_WAIT != 0) begin
                  state    <= S_MWAIT;
                  wait_cnt <= WAIT_INIT;
               end else if (state == last) begin
                  state <= Stop ? S_PAUSE : S_T0;
               end else begin
                  state <= state_t'(state + 4'd1);
               end
            end
            S_MWAIT: begin
               if (wait_cnt == 3'd0) begin
                  if (last == S_T6) state <= Stop ? S_PAUSE : S_T0;
                  else              state <= S_T7;
               end else begin
                  wait_cnt <= wait_cnt - 3'd1;
               end
            end
            S_PAUSE: if (!Stop) state <= S_T0;
            S_HALT:  state <= S_HALT;
            default: state <= S_RST;
         endcase
      end
   end

   assign HiIn      = cw.hi_in;
   assign LoIn      = cw.lo_in;
   assign ZIn       = cw.z_in;
   assign PCIn      = cw.pc_in;
   assign MDRIn     = cw.mdr_in;
   assign MARIn     = cw.mar_in;
   assign YIn       = cw.y_in;
   assign OPortIn   = cw.oport_in;
   assign IRIn      = cw.ir_in;
   assign HiSel     = cw.hi_sel;
   assign LoSel     = cw.lo_sel;
   assign ZHiSel    = cw.zhi_sel;
   assign ZLoSel    = cw.zlo_sel;
   assign PCSel     = cw.pc_sel;
   assign MDRSel    = cw.mdr_sel;
   assign IPortSel  = cw.iport_sel;
   assign CSel      = cw.c_sel;
   assign Gra       = cw.gra;
   assign Grb       = cw.grb;
   assign Grc       = cw.grc;
   assign RIn       = cw.r_in;
   assign ROut      = cw.r_out;
   assign BAOut     = cw.ba_out;
   assign ConIn     = cw.con_in;
   assign memread   = cw.mem_read;
   assign memwrite  = cw.mem_write;
   assign ALUCode   = cw.alu_code;
   assign Run       = cw.run;
   assign IllegalOp = cw.illegal_op;

   // Only one driver may own the bus in any cycle.
   bus_one_driver: assert property (@(posedge clock) disable iff (!clear)
      $onehot0({HiSel, LoSel, ZHiSel, ZLoSel, PCSel, MDRSel, IPortSel, CSel, ROut, BAOut}));

   mem_strobe_excl: assert property (@(posedge clock) disable iff (!clear)
      !(memread && memwrite));

endmodule
